ks_son: RTL and testbench

- Downstream neighbour of the distance-4 Kogge-Stone prefix stage in the execute-unit adder.
- Consumes that stage's carry-in, partial propagate/generate vectors and saved bitwise propagate.
- Completes the prefix tree (distances 8, 16, 32), forms the 32-bit sum and status flags, and registers results in a 2-stage valid/ready pipeline so the adder can be retimed into the execute stage.

---
 rtl/ks_son_if.sv | 28 ++
 rtl/ks_son.sv | 109 ++++++++++
 tb/tb_ks_son.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_son_if.sv
// Handshake and data bundle between the distance-4 prefix stage,
// ks_son and the consumer of the adder result.
//   slave : ks_son view (takes prefix vectors, returns the sum)
//   master: upstream/downstream view (drives prefix vectors and i_ready)
interface ks_son_if;
    logic        i_valid;
    logic        o_ready;
    logic        i_c0;
    logic [24:0] i_pk;
    logic [31:0] i_gk;
    logic [31:0] i_p_save;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_sum;
    logic        o_cout;
    logic        o_ovf;
    logic        o_zero;

    modport slave (
        input  i_valid, i_c0, i_pk, i_gk, i_p_save, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero
    );

    modport master (
        output i_valid, i_c0, i_pk, i_gk, i_p_save, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero
    );
endinterface

// File: rtl/ks_son.sv
// Kogge-Stone prefix completion (distances 8/16/32), sum and flags,
// in a 2-stage valid/ready pipeline.
// Ports: i_clk, i_rst (sync, active high), bus (ks_son_if.slave):
//   in : i_valid, i_c0, i_pk[24:0], i_gk[31:0], i_p_save[31:0], i_ready
//   out: o_ready, o_valid, o_sum[31:0], o_cout, o_ovf, o_zero
module ks_son (
    input  logic    i_clk,
    input  logic    i_rst,
    ks_son_if.slave bus
);

    // Generate vector shifted up by one with c0 in slot 0, so that
    // gx[i-7] is G[i-8] and position -1 maps to the carry-in.
    logic [24:0] gx;
    logic [31:0] g8;
    logic [16:0] p8;   // p8[j] is the span ending at position j+15
    logic [16:0] gx8;  // gx8[i-15] is G'[i-16]
    logic [31:0] g16;
    logic        p16;  // span ending at position 31

    always_comb begin
        gx = {bus.i_gk[23:0], bus.i_c0};
        g8 = bus.i_gk;
        for (int i = 7; i < 32; i++) begin
            g8[i] = bus.i_gk[i] | (bus.i_pk[i-7] & gx[i-7]);
        end
        p8 = '0;
        for (int j = 0; j < 17; j++) begin
            p8[j] = bus.i_pk[j+8] & bus.i_pk[j];
        end
    end

    always_comb begin
        gx8 = {g8[15:0], bus.i_c0};
        g16 = g8;
        for (int i = 15; i < 32; i++) begin
            g16[i] = g8[i] | (p8[i-15] & gx8[i-15]);
        end
        p16 = p8[16] & p8[0];
    end

    logic s1_v;
    logic s2_v;
    logic s1_en;
    logic s2_en;

    assign s2_en = ~s2_v | bus.i_ready;
    assign s1_en = ~s1_v | s2_en;

    logic [31:0] s1_g;
    logic        s1_p;
    logic [31:0] s1_ps;
    logic        s1_c0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v  <= 1'b0;
            s1_g  <= '0;
            s1_p  <= 1'b0;
            s1_ps <= '0;
            s1_c0 <= 1'b0;
        end else if (s1_en) begin
            s1_v  <= bus.i_valid;
            s1_g  <= g16;
            s1_p  <= p16;
            s1_ps <= bus.i_p_save;
            s1_c0 <= bus.i_c0;
        end
    end

    // Final grey cell at 31 folds in c0; every carry is then complete.
    logic [31:0] c;
    logic [31:0] sum;

    always_comb begin
        c     = s1_g;
        c[31] = s1_g[31] | (s1_p & s1_c0);
        sum   = s1_ps ^ {c[30:0], s1_c0};
    end

    logic [31:0] r_sum;
    logic        r_cout;
    logic        r_ovf;
    logic        r_zero;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_v   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (s2_en) begin
            s2_v   <= s1_v;
            r_sum  <= sum;
            r_cout <= c[31];
            r_ovf  <= c[31] ^ c[30];
            r_zero <= ~|sum;
        end
    end

    assign bus.o_ready = s1_en;
    assign bus.o_valid = s2_v;
    assign bus.o_sum   = r_sum;
    assign bus.o_cout  = r_cout;
    assign bus.o_ovf   = r_ovf;
    assign bus.o_zero  = r_zero;

endmodule

// File: tb/tb_ks_son.sv
// Scoreboard bench for ks_son: operands are turned into distance-4
// prefix vectors by a span model and results are checked against a+b+c0.
module tb_ks_son;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ks_son_if bus();

    ks_son dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc_cyc;
        logic        lat_chk;
    } exp_t;

    exp_t q[$];

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_del = 0;
    int cyc   = 0;
    logic lat_mode = 1'b0;

    logic [31:0] cur_a;
    logic [31:0] cur_b;
    logic        cur_c0;

    always @(posedge clk) cyc++;

    // Carry out of position i over bits i-7..i, or over the whole
    // low part plus c0 when that span reaches below bit 0.
    function automatic logic [31:0] mdl_gk(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic c0);
        logic [31:0] g;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] s;
        for (int i = 0; i < 32; i++) begin
            if (i < 7) begin
                x = {32'd0, a} & ((64'd1 << (i + 1)) - 64'd1);
                y = {32'd0, b} & ((64'd1 << (i + 1)) - 64'd1);
                s = x + y + {63'd0, c0};
                g[i] = s[i+1];
            end else begin
                x = ({32'd0, a} >> (i - 7)) & 64'hFF;
                y = ({32'd0, b} >> (i - 7)) & 64'hFF;
                s = x + y;
                g[i] = s[8];
            end
        end
        return g;
    endfunction

    function automatic logic [24:0] mdl_pk(input logic [31:0] a,
                                           input logic [31:0] b);
        logic [24:0] p;
        logic [31:0] x;
        for (int k = 0; k < 25; k++) begin
            x = (a ^ b) >> k;
            p[k] = (x[7:0] == 8'hFF);
        end
        return p;
    endfunction

    function automatic exp_t mdl_res(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic c0);
        exp_t e;
        logic [32:0] t;
        t = {1'b0, a} + {1'b0, b} + {32'd0, c0};
        e.sum  = t[31:0];
        e.cout = t[32];
        e.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
        e.zero = (t[31:0] == 32'd0);
        e.acc_cyc = 0;
        e.lat_chk = 1'b0;
        return e;
    endfunction

    task automatic new_ops();
        cur_a  = $urandom;
        cur_b  = $urandom;
        cur_c0 = 1'($urandom % 2);
        case ($urandom % 8)
            0: cur_a = 32'hFFFF_FFFF;
            1: cur_b = ~cur_a;
            2: cur_a = 32'h7FFF_FFFF;
            default: ;
        endcase
    endtask

    // One cycle: drive after the edge, decide acceptance at the negedge.
    task automatic step(input logic v, input logic rdy, output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        bus.i_valid  = v;
        bus.i_ready  = rdy;
        bus.i_c0     = cur_c0;
        bus.i_gk     = mdl_gk(cur_a, cur_b, cur_c0);
        bus.i_pk     = mdl_pk(cur_a, cur_b);
        bus.i_p_save = cur_a ^ cur_b;
        @(negedge clk);
        acc = bus.i_valid && bus.o_ready;
        if (acc) begin
            e = mdl_res(cur_a, cur_b, cur_c0);
            e.acc_cyc = cyc;
            e.lat_chk = lat_mode;
            q.push_back(e);
            n_acc++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, acc);
    endtask

    task automatic chk_reset_state();
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_o_sum", bus.o_sum, 32'd0);
        chk("rst_flags", {29'd0, bus.o_cout, bus.o_ovf, bus.o_zero}, 32'd0);
        chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
    endtask

    logic        hold_prev = 1'b0;
    logic [34:0] hold_val;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (bus.o_valid && !bus.i_ready) begin
                if (hold_prev)
                    chk("hold_stable",
                        {bus.o_sum[28:0], bus.o_cout, bus.o_ovf, bus.o_zero},
                        hold_val[31:0]);
                hold_prev = 1'b1;
                hold_val  = {bus.o_sum, bus.o_cout, bus.o_ovf, bus.o_zero};
            end else begin
                hold_prev = 1'b0;
            end
            if (bus.o_valid && bus.i_ready) begin
                n_del++;
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_result: got %h with nothing expected",
                             bus.o_sum);
                end else begin
                    e = q.pop_front();
                    chk("result_sum", bus.o_sum, e.sum);
                    chk("result_flags",
                        {29'd0, bus.o_cout, bus.o_ovf, bus.o_zero},
                        {29'd0, e.cout, e.ovf, e.zero});
                    if (e.lat_chk)
                        chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   cnt;
        int   guard;
        logic nr_seen;

        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_c0     = 1'b0;
        bus.i_gk     = '0;
        bus.i_pk     = '0;
        bus.i_p_save = '0;
        cur_a = 0;
        cur_b = 0;
        cur_c0 = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_state();

        // Directed: wrap to zero, then c0 rippling through all positions.
        lat_mode = 1'b1;
        cur_a = 32'hFFFF_FFFF; cur_b = 32'h1; cur_c0 = 1'b0;
        step(1'b1, 1'b1, acc);
        chk("dir1_accept", 32'(acc), 32'd1);
        cur_a = 32'h7FFF_FFFF; cur_b = 32'h0; cur_c0 = 1'b1;
        step(1'b1, 1'b1, acc);
        chk("dir2_accept", 32'(acc), 32'd1);
        drain(4);

        // Back-to-back stream.
        nr_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            new_ops();
            step(1'b1, 1'b1, acc);
            if (!acc) nr_seen = 1'b1;
        end
        chk("stream_ready", 32'(nr_seen), 32'd0);
        drain(4);
        lat_mode = 1'b0;

        // Stall: exactly two entries can be buffered.
        cnt = 0;
        new_ops();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, acc);
            if (acc) begin
                cnt++;
                new_ops();
            end
        end
        chk("stall_accepts", 32'(cnt), 32'd2);
        chk("stall_o_ready", 32'(bus.o_ready), 32'd0);
        drain(5);
        chk("stall_drained", 32'(q.size()), 32'd0);

        // Random valid/ready toggling.
        cnt = 0;
        guard = 0;
        new_ops();
        while (cnt < 2000 && guard < 20000) begin
            step(1'($urandom % 2), 1'($urandom % 2), acc);
            if (acc) begin
                cnt++;
                new_ops();
            end
            guard++;
        end
        chk("random_count", 32'(cnt), 32'd2000);
        drain(6);
        chk("random_drained", 32'(q.size()), 32'd0);

        // Fill both stages, then reset: nothing may come out.
        cnt = 0;
        new_ops();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, acc);
            if (acc) begin
                cnt++;
                new_ops();
            end
        end
        chk("flush_filled", 32'(cnt), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        n_acc -= q.size();
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_state();
        drain(5);

        chk("acc_eq_del", 32'(n_acc), 32'(n_del));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
